spi_master: RTL and testbench



---
 rtl/spi_master.sv | 203 ++++++++++++++++++++
 tb/tb_spi_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Byte-oriented SPI master, CPOL=0, MSB first.
// Sends one byte per accepted start and can keep cs low across a burst of
// bytes. sck is a registered clock kept slow so the far-side glitch filter
// sees clean edges.
//
// Ports:
//   clk      main clock
//   rst_n    synchronous active-low reset
//   start    transfer request, accepted only while busy=0
//   last     sampled with an accepted start; 1 = release cs after this byte
//   stop     in HOLD: close the burst without sending another byte
//   tx_data  byte to send, sampled with an accepted start
//   rx_data  byte received on sdi, valid from done onward
//   done     one-cycle pulse when a byte completes
//   busy     1 = start is not accepted this cycle
//   sck      spi clock, idle 0
//   cs       spi chip select, active low, idle 1
//   sdo      spi data out (MOSI), idle 0
//   sdi      spi data in (MISO), asynchronous to clk
module spi_master #(
  parameter int unsigned CLK_DIV  = 16,
  parameter int unsigned CS_SETUP = 16,
  parameter int unsigned CS_HOLD  = 16,
  parameter int unsigned CS_IDLE  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       last,
  input  logic       stop,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       done,
  output logic       busy,
  output logic       sck,
  output logic       cs,
  output logic       sdo,
  input  logic       sdi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_LOW,
    S_HIGH,
    S_TRAIL,
    S_HOLD,
    S_GAP
  } state_t;

  // Terminal counts: each timed state runs for exactly N cycles.
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        sck_q, sck_d;
  logic        cs_q, cs_d;
  logic        sdo_q, sdo_d;
  logic        sdi_meta_q, sdi_meta_d;
  logic        sdi_sync_q, sdi_sync_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      sdo_q      <= 1'b0;
      sdi_meta_q <= 1'b0;
      sdi_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      last_q     <= last_d;
      done_q     <= done_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      sdo_q      <= sdo_d;
      sdi_meta_q <= sdi_meta_d;
      sdi_sync_q <= sdi_sync_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    last_d     = last_q;
    done_d     = 1'b0;
    sck_d      = sck_q;
    cs_d       = cs_q;
    sdo_d      = sdo_q;
    sdi_meta_d = sdi;
    sdi_sync_d = sdi_meta_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          tx_d    = tx_data;
          last_d  = last;
          bit_d   = '0;
          cs_d    = 1'b0;
          sdo_d   = tx_data[7];
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (cnt_q == DIV_LAST) begin
          // Falling edge: capture sdi, then either present the next bit
          // or finish the byte.
          cnt_d   = '0;
          sck_d   = 1'b0;
          rx_sh_d = {rx_sh_q[6:0], sdi_sync_q};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            rx_data_d = {rx_sh_q[6:0], sdi_sync_q};
            done_d    = 1'b1;
            sdo_d     = 1'b0;
            state_d   = last_q ? S_TRAIL : S_HOLD;
          end else begin
            sdo_d   = tx_q[6];
            tx_d    = {tx_q[6:0], 1'b0};
            state_d = S_LOW;
          end
        end
      end
      S_HOLD: begin
        cnt_d = '0;
        // start has priority over stop.
        if (start) begin
          tx_d    = tx_data;
          last_d  = last;
          bit_d   = '0;
          sdo_d   = tx_data[7];
          state_d = S_LOW;
        end else if (stop) begin
          state_d = S_TRAIL;
        end
      end
      S_TRAIL: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == IDLE_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_data = rx_data_q;
  assign done    = done_q;
  assign busy    = (state_q != S_IDLE) && (state_q != S_HOLD);
  assign sck     = sck_q;
  assign cs      = cs_q;
  assign sdo     = sdo_q;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  localparam int unsigned P_DIV   = 4;
  localparam int unsigned P_SETUP = 4;
  localparam int unsigned P_HOLD  = 4;
  localparam int unsigned P_IDLE  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       last = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       done, busy, sck, cs, sdo, sdi;
  logic       loop_en = 1'b1;
  logic       sdi_const = 1'b0;

  assign sdi = loop_en ? sdo : sdi_const;

  always #5 clk = ~clk;

  spi_master #(
    .CLK_DIV (P_DIV),
    .CS_SETUP(P_SETUP),
    .CS_HOLD (P_HOLD),
    .CS_IDLE (P_IDLE)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .last   (last),
    .stop   (stop),
    .tx_data(tx_data),
    .rx_data(rx_data),
    .done   (done),
    .busy   (busy),
    .sck    (sck),
    .cs     (cs),
    .sdo    (sdo),
    .sdi    (sdi)
  );

  int total = 0;
  int bad = 0;

  // Pin monitor, sampled on the inactive edge.
  int         cyc = 0;
  int         rise_cnt = 0, done_cnt = 0, csfall_cnt = 0, csrise_cnt = 0;
  int         sdo_hi = 0, sdo_bad = 0;
  int         t_csfall = 0, t_csrise = 0, t_done = 0, t_busyfall = 0;
  logic [7:0] mosi = 8'h00;
  logic       p_sck = 1'b0, p_cs = 1'b1, p_sdo = 1'b0, p_busy = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (p_cs === 1'b1 && cs === 1'b0) begin
      t_csfall   <= cyc;
      csfall_cnt <= csfall_cnt + 1;
    end
    if (p_cs === 1'b0 && cs === 1'b1) begin
      t_csrise   <= cyc;
      csrise_cnt <= csrise_cnt + 1;
    end
    if (done === 1'b1) begin
      t_done   <= cyc;
      done_cnt <= done_cnt + 1;
    end
    if (p_sck === 1'b0 && sck === 1'b1) begin
      rise_cnt <= rise_cnt + 1;
      mosi     <= {mosi[6:0], sdo};
    end
    if (sdo !== p_sdo && sck === 1'b1) sdo_bad <= sdo_bad + 1;
    if (cs === 1'b0 && sdo === 1'b1) sdo_hi <= sdo_hi + 1;
    if (p_busy === 1'b1 && busy === 1'b0) t_busyfall <= cyc;
    p_sck  <= sck;
    p_cs   <= cs;
    p_sdo  <= sdo;
    p_busy <= busy;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] d, input logic l, input logic st);
    @(negedge clk);
    tx_data = d;
    last    = l;
    stop    = st;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s: done never seen, expected within 2000 cycles", name);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL %s: busy stuck at %b, expected 0", name, busy);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       loop;
    logic       sdi_v;
    logic [7:0] exp_rx;
    logic       quiet;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_rise, b_done, b_fall, b_rise_cs, b_hi, n;

    vecs[0] = '{tx: 8'hA5, loop: 1'b1, sdi_v: 1'b0, exp_rx: 8'hA5, quiet: 1'b0};
    vecs[1] = '{tx: 8'h00, loop: 1'b0, sdi_v: 1'b1, exp_rx: 8'hFF, quiet: 1'b1};
    vecs[2] = '{tx: 8'h3C, loop: 1'b0, sdi_v: 1'b0, exp_rx: 8'h00, quiet: 1'b0};
    vecs[3] = '{tx: 8'h81, loop: 1'b1, sdi_v: 1'b0, exp_rx: 8'h81, quiet: 1'b0};
    vecs[4] = '{tx: 8'h5A, loop: 1'b0, sdi_v: 1'b1, exp_rx: 8'hFF, quiet: 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs", cs, 1);
    chk("rst_sck", sck, 0);
    chk("rst_sdo", sdo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rx_data, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single-byte frames
    for (int unsigned i = 0; i < 5; i++) begin
      loop_en   = vecs[i].loop;
      sdi_const = vecs[i].sdi_v;
      b_rise = rise_cnt;
      b_done = done_cnt;
      b_hi   = sdo_hi;
      pulse_start(vecs[i].tx, 1'b1, 1'b0);
      chk("vec_busy", busy, 1);
      wait_done("vec_done");
      chk("vec_rx", rx_data, vecs[i].exp_rx);
      wait_idle("vec_idle");
      @(negedge clk);
      chk("vec_rises", rise_cnt - b_rise, 8);
      chk("vec_done_cnt", done_cnt - b_done, 1);
      chk("vec_mosi", mosi, vecs[i].tx);
      chk("vec_t_done", t_done - t_csfall, P_SETUP + 16 * P_DIV);
      chk("vec_t_cshold", t_csrise - t_done, P_HOLD);
      chk("vec_t_gap", t_busyfall - t_csrise, P_IDLE);
      chk("vec_cs_end", cs, 1);
      if (vecs[i].quiet) chk("vec_sdo_quiet", sdo_hi - b_hi, 0);
    end

    // Burst of two bytes with cs held low
    loop_en = 1'b1;
    b_rise = rise_cnt; b_done = done_cnt; b_fall = csfall_cnt; b_rise_cs = csrise_cnt;
    pulse_start(8'h3C, 1'b0, 1'b0);
    wait_done("burst_done1");
    chk("burst_rx1", rx_data, 8'h3C);
    repeat (3) @(negedge clk);
    chk("burst_hold_busy", busy, 0);
    chk("burst_hold_cs", cs, 0);
    chk("burst_hold_sck", sck, 0);
    pulse_start(8'hC3, 1'b1, 1'b0);
    wait_done("burst_done2");
    chk("burst_rx2", rx_data, 8'hC3);
    wait_idle("burst_idle");
    @(negedge clk);
    chk("burst_rises", rise_cnt - b_rise, 16);
    chk("burst_dones", done_cnt - b_done, 2);
    chk("burst_csfalls", csfall_cnt - b_fall, 1);
    chk("burst_csrises", csrise_cnt - b_rise_cs, 1);
    chk("burst_mosi", mosi, 8'hC3);

    // start and stop together in HOLD: start wins; later stop alone closes
    b_rise = rise_cnt; b_done = done_cnt;
    pulse_start(8'h5A, 1'b0, 1'b0);
    wait_done("ss_done1");
    repeat (2) @(negedge clk);
    pulse_start(8'h96, 1'b0, 1'b1);
    wait_done("ss_done2");
    chk("ss_rx2", rx_data, 8'h96);
    repeat (2) @(negedge clk);
    chk("ss_hold_busy", busy, 0);
    chk("ss_hold_cs", cs, 0);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_cs_low", cs, 0);
    n = 0;
    while (cs !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stop_cs_hold", n, P_HOLD);
    wait_idle("stop_idle");
    @(negedge clk);
    chk("stop_rises", rise_cnt - b_rise, 16);
    chk("stop_dones", done_cnt - b_done, 2);

    // start during GAP is dropped; stop in IDLE is ignored
    b_fall = csfall_cnt; b_done = done_cnt;
    pulse_start(8'h11, 1'b1, 1'b0);
    wait_done("gap_done");
    repeat (P_HOLD + 2) @(negedge clk);
    chk("gap_busy", busy, 1);
    chk("gap_cs", cs, 1);
    pulse_start(8'hFF, 1'b1, 1'b0);
    wait_idle("gap_idle");
    repeat (4) @(negedge clk);
    chk("gap_cs_idle", cs, 1);
    chk("gap_csfalls", csfall_cnt - b_fall, 1);
    chk("gap_dones", done_cnt - b_done, 1);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_stop_cs", cs, 1);
    chk("idle_stop_busy", busy, 0);

    // Reset in the 4th HIGH phase, then a clean frame
    b_rise = rise_cnt; b_done = done_cnt;
    pulse_start(8'hA5, 1'b1, 1'b0);
    n = 0;
    while (rise_cnt - b_rise < 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached", (rise_cnt - b_rise >= 4) ? 1 : 0, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstm_cs", cs, 1);
    chk("rstm_sck", sck, 0);
    chk("rstm_sdo", sdo, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_done", done, 0);
    chk("rstm_rx", rx_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstm_no_done", done_cnt - b_done, 0);
    b_rise = rise_cnt;
    pulse_start(8'h3C, 1'b1, 1'b0);
    wait_done("rstm_new_done");
    chk("rstm_new_rx", rx_data, 8'h3C);
    wait_idle("rstm_new_idle");
    @(negedge clk);
    chk("rstm_new_rises", rise_cnt - b_rise, 8);
    chk("rstm_new_mosi", mosi, 8'h3C);

    chk("sdo_on_rise", sdo_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
